clk_div_ctrl: RTL and testbench



---
 rtl/clk_div_ctrl_pkg.sv | 14 +
 rtl/clk_div_core.sv | 47 ++++
 rtl/clk_div_ctrl.sv | 137 +++++++++++++
 tb/tb_clk_div_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_ctrl_pkg.sv
// Shared types and defaults for the run-time configurable clock divider.
package clk_div_ctrl_pkg;

   localparam int CNT_W_DEF     = 16;
   localparam int DEFAULT_N_DEF = 50;

   typedef enum logic [1:0] {
      ST_STOP  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PEND  = 2'd2,
      ST_DRAIN = 2'd3
   } state_e;

endpackage

// File: rtl/clk_div_core.sv
// Half-period down-counter and output toggle flop of the clock divider.
module clk_div_core
   import clk_div_ctrl_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk_in,
   input  logic             rst_n,
   input  logic             run,
   input  logic [CNT_W-1:0] n,
   output logic             tgl,
   output logic             clk_div
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             clk_div_q, clk_div_d;

   // n is the ratio in force after this edge, so a reload always uses the new ratio.
   assign tgl = run && (cnt_q == '0);

   always_comb begin
      cnt_d     = cnt_q;
      clk_div_d = clk_div_q;
      if (!run) begin
         cnt_d     = n - CNT_W'(1);
         clk_div_d = 1'b0;
      end else if (tgl) begin
         cnt_d     = n - CNT_W'(1);
         clk_div_d = !clk_div_q;
      end else begin
         cnt_d     = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         clk_div_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         clk_div_q <= clk_div_d;
      end
   end

   assign clk_div = clk_div_q;

endmodule

// File: rtl/clk_div_ctrl.sv
// Even clock divider with valid/ready ratio change on full-period boundaries.
// Optional TICK register enabled by defining CLK_DIV_CTRL_TICK_EN.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_STOP  | output held low, ratio loads directly on config
// ST_RUN   | dividing at n_cur, config accepted into n_pend
// ST_PEND  | old ratio running, n_pend applied at next falling toggle
// ST_DRAIN | finishing the high half before stopping, EN ignored
module clk_div_ctrl
   import clk_div_ctrl_pkg::*;
#(
   parameter int CNT_W     = CNT_W_DEF,
   parameter int DEFAULT_N = DEFAULT_N_DEF
) (
   input  logic             CLK_IN,
   input  logic             RST_N,
   input  logic             EN,
   input  logic             CFG_VALID,
   output logic             CFG_READY,
   input  logic [CNT_W-1:0] CFG_N,
   output logic             CLK_DIV,
   output logic             TICK,
   output logic             LOCKED,
   output logic             ERR
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] n_cur_q, n_cur_d;
   logic [CNT_W-1:0] n_pend_q, n_pend_d;
   logic             locked_q, locked_d;
   logic             err_q, err_d;

   logic             run;
   logic             tgl;
   logic             clk_div;
   logic             rise;
   logic             fall;
   logic             cfg_acc;
   logic             cfg_ok;
   logic             cfg_bad;

   // In DRAIN with the output already low the counter must not produce a rising toggle.
   assign run       = (state_q != ST_STOP) && !((state_q == ST_DRAIN) && !clk_div);
   assign rise      = tgl && !clk_div;
   assign fall      = tgl && clk_div;
   assign CFG_READY = (state_q == ST_STOP) || (state_q == ST_RUN);
   assign cfg_acc   = CFG_VALID && CFG_READY;
   assign cfg_ok    = cfg_acc && (CFG_N != '0);
   assign cfg_bad   = cfg_acc && (CFG_N == '0);

   always_comb begin
      state_d  = state_q;
      n_cur_d  = n_cur_q;
      n_pend_d = n_pend_q;
      err_d    = err_q || cfg_bad;
      unique case (state_q)
         ST_STOP: begin
            if (cfg_ok) n_cur_d = CFG_N;
            if (EN) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (cfg_ok) n_pend_d = CFG_N;
            if (!EN)         state_d = ST_DRAIN;
            else if (cfg_ok) state_d = ST_PEND;
         end
         ST_PEND: begin
            if (!EN) begin
               state_d = ST_DRAIN;
            end else if (fall) begin
               n_cur_d  = n_pend_q;
               n_pend_d = '0;
               state_d  = ST_RUN;
            end
         end
         ST_DRAIN: begin
            // n_pend of zero means nothing is pending, since zero is never accepted.
            if (!clk_div || fall) begin
               state_d = ST_STOP;
               if (n_pend_q != '0) begin
                  n_cur_d  = n_pend_q;
                  n_pend_d = '0;
               end
            end
         end
         default: state_d = ST_STOP;
      endcase
      locked_d = (state_d == ST_RUN) && (locked_q || ((state_q == ST_RUN) && rise));
   end

   always_ff @(posedge CLK_IN or negedge RST_N) begin
      if (!RST_N) begin
         state_q  <= ST_STOP;
         n_cur_q  <= CNT_W'(DEFAULT_N);
         n_pend_q <= '0;
         locked_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         n_cur_q  <= n_cur_d;
         n_pend_q <= n_pend_d;
         locked_q <= locked_d;
         err_q    <= err_d;
      end
   end

   clk_div_core #(
      .CNT_W (CNT_W)
   ) u_core (
      .clk_in  (CLK_IN),
      .rst_n   (RST_N),
      .run     (run),
      .n       (n_cur_d),
      .tgl     (tgl),
      .clk_div (clk_div)
   );

`ifdef CLK_DIV_CTRL_TICK_EN
   logic tick_q, tick_d;

   assign tick_d = rise;

   always_ff @(posedge CLK_IN or negedge RST_N) begin
      if (!RST_N) tick_q <= 1'b0;
      else        tick_q <= tick_d;
   end

   assign TICK = tick_q;
`else
   assign TICK = 1'b0;
`endif

   assign CLK_DIV = clk_div;
   assign LOCKED  = locked_q;
   assign ERR     = err_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed self-checking bench for clk_div_ctrl: ratio table plus corner-case sequences.
module tb_clk_div_ctrl;

   localparam int MAXC = 400;
`ifdef CLK_DIV_CTRL_TICK_EN
   localparam int TICK_ON = 1;
`else
   localparam int TICK_ON = 0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic        cfg_valid = 1'b0;
   logic        cfg_ready;
   logic [15:0] cfg_n = '0;
   logic        clk_div;
   logic        tick;
   logic        locked;
   logic        err;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   typedef struct {
      logic        do_cfg;
      logic [15:0] n;
      int          exp_first;
      int          exp_hi;
      int          exp_lo;
      int          exp_ticks;
      int          exp_drain;
   } vec_t;

   vec_t vecs[4];

   clk_div_ctrl dut (
      .CLK_IN    (clk),
      .RST_N     (rst_n),
      .EN        (en),
      .CFG_VALID (cfg_valid),
      .CFG_READY (cfg_ready),
      .CFG_N     (cfg_n),
      .CLK_DIV   (clk_div),
      .TICK      (tick),
      .LOCKED    (locked),
      .ERR       (err)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cycles_until(input logic lvl, output int n);
      n = 0;
      do begin
         step();
         n++;
      end while ((clk_div !== lvl) && (n < MAXC));
   endtask

   task automatic chk(input string name, input int act, input int exp);
      chk_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic offer(input logic [15:0] n);
      cfg_valid = 1'b1;
      cfg_n     = n;
      step();
      cfg_valid = 1'b0;
   endtask

   initial begin
      int c;
      int ticks;

      vecs[0] = '{1'b0, 16'd50, 50, 50, 50, 2, 50};
      vecs[1] = '{1'b1, 16'd1,   1,  1,  1, 2,  1};
      vecs[2] = '{1'b1, 16'd3,   3,  3,  3, 2,  3};
      vecs[3] = '{1'b1, 16'd10, 10, 10, 10, 2, 10};

      // reset values
      step();
      step();
      chk("rst_clk_div", int'(clk_div), 0);
      chk("rst_tick", int'(tick), 0);
      chk("rst_locked", int'(locked), 0);
      chk("rst_err", int'(err), 0);
      chk("rst_ready", int'(cfg_ready), 1);
      rst_n = 1'b1;
      step();

      // ratio table: configure in STOP, run, measure, drain
      for (int i = 0; i < 4; i++) begin
         if (vecs[i].do_cfg) offer(vecs[i].n);
         en = 1'b1;
         step();
         chk($sformatf("v%0d_lock_pre", i), int'(locked), 0);
         cycles_until(1'b1, c);
         chk($sformatf("v%0d_first_rise", i), c, vecs[i].exp_first);
         chk($sformatf("v%0d_tick_at_rise", i), int'(tick), TICK_ON);
         chk($sformatf("v%0d_lock", i), int'(locked), 1);
         cycles_until(1'b0, c);
         chk($sformatf("v%0d_high_half", i), c, vecs[i].exp_hi);
         cycles_until(1'b1, c);
         chk($sformatf("v%0d_low_half", i), c, vecs[i].exp_lo);
         ticks = 0;
         for (int j = 0; j < 4 * int'(vecs[i].n); j++) begin
            step();
            if (tick === 1'b1) ticks++;
         end
         chk($sformatf("v%0d_ticks", i), ticks, vecs[i].exp_ticks * TICK_ON);
         en = 1'b0;
         cycles_until(1'b0, c);
         chk($sformatf("v%0d_drain", i), c, vecs[i].exp_drain);
         step();
         step();
         chk($sformatf("v%0d_stop_ready", i), int'(cfg_ready), 1);
      end

      // illegal ratio in RUN at N=10
      en = 1'b1;
      step();
      cycles_until(1'b1, c);
      chk("err_first_rise", c, 10);
      offer(16'd0);
      chk("err_set", int'(err), 1);
      chk("err_ready", int'(cfg_ready), 1);
      chk("err_locked", int'(locked), 1);
      cycles_until(1'b0, c);
      chk("err_rest_high", c, 9);
      cycles_until(1'b1, c);
      chk("err_low", c, 10);
      cycles_until(1'b0, c);
      chk("err_high", c, 10);
      chk("err_sticky", int'(err), 1);

      // async reset mid-run with output high
      cycles_until(1'b1, c);
      chk("rst2_rise", c, 10);
      step();
      step();
      rst_n = 1'b0;
      #1;
      chk("rst2_clk_div", int'(clk_div), 0);
      chk("rst2_err", int'(err), 0);
      chk("rst2_locked", int'(locked), 0);
      en = 1'b0;
      step();
      rst_n = 1'b1;
      step();

      // ratio change 50 -> 10 on a full-period boundary
      en = 1'b1;
      step();
      cycles_until(1'b1, c);
      chk("pend_first_rise", c, 50);
      offer(16'd10);
      chk("pend_ready_low", int'(cfg_ready), 0);
      chk("pend_unlocked", int'(locked), 0);
      cycles_until(1'b0, c);
      chk("pend_old_high", c, 49);
      chk("pend_ready_back", int'(cfg_ready), 1);
      cycles_until(1'b1, c);
      chk("pend_new_low", c, 10);
      chk("pend_relock", int'(locked), 1);
      cycles_until(1'b0, c);
      chk("pend_new_high", c, 10);

      // reset while a ratio is pending discards it
      cycles_until(1'b1, c);
      chk("rstp_rise", c, 10);
      offer(16'd3);
      chk("rstp_ready_low", int'(cfg_ready), 0);
      step();
      step();
      rst_n = 1'b0;
      #1;
      chk("rstp_clk_div", int'(clk_div), 0);
      chk("rstp_ready", int'(cfg_ready), 1);
      en = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      en = 1'b1;
      step();
      cycles_until(1'b1, c);
      chk("rstp_first_rise", c, 50);
      cycles_until(1'b0, c);
      chk("rstp_high", c, 50);

      // drop EN mid high half, re-raise during DRAIN
      cycles_until(1'b1, c);
      chk("drain_rise", c, 50);
      repeat (10) step();
      en = 1'b0;
      step();
      chk("drain_ready", int'(cfg_ready), 0);
      chk("drain_unlocked", int'(locked), 0);
      repeat (5) step();
      en = 1'b1;
      cycles_until(1'b0, c);
      chk("drain_rest_high", c, 34);
      cycles_until(1'b1, c);
      chk("drain_restart", c, 51);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
